// File: rtl/imem_arbiter.sv
// Arbitrates the single instruction-memory port between fetch and the debug/loader port.
// Debug may lock the memory; a bounded wait counter keeps fetch from starving debug.
module imem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,
    output logic        f_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic        d_lock_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        locked_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic {SHARED = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES) - 32'd4;
    localparam logic [3:0]  WAIT_LIM  = 4'(MAX_WAIT);

    state_t      r_state;
    logic [3:0]  r_wait;
    logic        r_f_rvalid;
    logic [31:0] r_f_rdata;
    logic        r_f_err;
    logic        r_d_rvalid;
    logic [31:0] r_d_rdata;
    logic        r_d_err;

    logic        w_f_win;
    logic        w_d_win;
    logic [31:0] w_addr;
    logic        w_in_range;

    // Grants are gated by reset so the write strobe drops the moment reset asserts.
    always_comb begin
        w_f_win = 1'b0;
        w_d_win = 1'b0;
        if (rstn_i) begin
            if (r_state == LOCKED) begin
                w_d_win = d_req_i;
            end else if (d_req_i && (!f_req_i || r_wait == WAIT_LIM)) begin
                w_d_win = 1'b1;
            end else begin
                w_f_win = f_req_i;
            end
        end
    end

    assign w_addr     = w_d_win ? d_addr_i : f_addr_i;
    assign w_in_range = (w_addr <= LAST_ADDR);

    assign f_gnt_o     = w_f_win;
    assign d_gnt_o     = w_d_win;
    assign mem_addr_o  = w_addr;
    assign mem_we_o    = w_d_win && d_we_i && w_in_range;
    assign mem_wdata_o = d_wdata_i;

    assign f_rvalid_o = r_f_rvalid;
    assign f_rdata_o  = r_f_rdata;
    assign f_err_o    = r_f_err;
    assign d_rvalid_o = r_d_rvalid;
    assign d_rdata_o  = r_d_rdata;
    assign d_err_o    = r_d_err;
    assign locked_o   = (r_state == LOCKED);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= SHARED;
            r_wait     <= 4'd0;
            r_f_rvalid <= 1'b0;
            r_f_rdata  <= 32'd0;
            r_f_err    <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= 32'd0;
            r_d_err    <= 1'b0;
        end else begin
            if (d_req_i && !w_d_win) begin
                if (r_wait < WAIT_LIM) r_wait <= r_wait + 4'd1;
            end else begin
                r_wait <= 4'd0;
            end

            if (w_d_win) r_state <= d_lock_i ? LOCKED : SHARED;

            // Data is zeroed for idle cycles, out-of-range accesses and debug writes.
            r_f_rvalid <= w_f_win;
            r_f_rdata  <= (w_f_win && w_in_range) ? mem_rdata_i : 32'd0;
            r_f_err    <= w_f_win && !w_in_range;
            r_d_rvalid <= w_d_win;
            r_d_rdata  <= (w_d_win && !d_we_i && w_in_range) ? mem_rdata_i : 32'd0;
            r_d_err    <= w_d_win && !w_in_range;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with its own copy of memory.
module tb_imem_arbiter;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned MAX_WAIT  = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        f_req_i = 1'b0;
    logic [31:0] f_addr_i = 32'd0;
    logic        f_gnt_o, f_rvalid_o, f_err_o;
    logic [31:0] f_rdata_o;
    logic        d_req_i = 1'b0, d_we_i = 1'b0, d_lock_i = 1'b0;
    logic [31:0] d_addr_i = 32'd0, d_wdata_i = 32'd0;
    logic        d_gnt_o, d_rvalid_o, d_err_o, locked_o;
    logic [31:0] d_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_we_o;

    int total = 0;
    int bad   = 0;

    imem_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
        .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_lock_i(d_lock_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .locked_o(locked_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Physical memory seen by the DUT; out-of-range reads return junk on purpose.
    logic [7:0] mem [0:MEM_BYTES-1];
    logic [9:0] w_idx;
    assign w_idx = mem_addr_o[9:0];
    assign mem_rdata_i = (mem_addr_o <= 32'd1020) ?
        {mem[w_idx + 10'd3], mem[w_idx + 10'd2], mem[w_idx + 10'd1], mem[w_idx]} : 32'hA5A5A5A5;
    always @(posedge clk_i) begin
        if (mem_we_o) begin
            mem[w_idx]         <= mem_wdata_o[7:0];
            mem[w_idx + 10'd1] <= mem_wdata_o[15:8];
            mem[w_idx + 10'd2] <= mem_wdata_o[23:16];
            mem[w_idx + 10'd3] <= mem_wdata_o[31:24];
        end
    end

    // Reference model state
    logic [7:0] m_mem [0:MEM_BYTES-1];
    bit         m_locked = 1'b0;
    int         m_waited = 0;

    // Expected and observed values of the last cycle driven
    logic        ex_fg, ex_dg, ex_we, ex_fv, ex_fe, ex_dv, ex_de, ex_lk;
    logic [31:0] ex_addr, ex_fd, ex_dd;
    logic        ob_fg, ob_dg, ob_we, ob_fv, ob_fe, ob_dv, ob_de, ob_lk;
    logic [31:0] ob_addr, ob_fd, ob_dd;

    function automatic bit inr(input logic [31:0] a);
        return a <= 32'(MEM_BYTES - 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!inr(a)) return 32'd0;
        return {m_mem[a + 3], m_mem[a + 2], m_mem[a + 1], m_mem[a]};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        mem[a]   = b;
        m_mem[a] = b;
    endtask

    // One clock cycle of stimulus; model predictions and DUT observations are captured
    task automatic cyc(input logic fr, input logic [31:0] fa, input logic dr, input logic dwe,
                       input logic dl, input logic [31:0] da, input logic [31:0] dw);
        @(negedge clk_i);
        f_req_i = fr; f_addr_i = fa;
        d_req_i = dr; d_we_i = dwe; d_lock_i = dl; d_addr_i = da; d_wdata_i = dw;
        ex_dg = dr && (m_locked || !fr || m_waited >= MAX_WAIT);
        ex_fg = fr && !m_locked && !ex_dg;
        ex_addr = ex_dg ? da : fa;
        ex_we = ex_dg && dwe && inr(da);
        ex_fv = ex_fg;
        ex_fd = m_read(fa);
        ex_fe = !inr(fa);
        ex_dv = ex_dg;
        ex_dd = dwe ? 32'd0 : m_read(da);
        ex_de = !inr(da);
        #1;
        ob_fg = f_gnt_o; ob_dg = d_gnt_o; ob_we = mem_we_o; ob_addr = mem_addr_o;
        @(posedge clk_i);
        if (ex_we) for (int k = 0; k < 4; k++) m_mem[da + k] = dw[8*k +: 8];
        if (ex_dg) m_locked = dl;
        if (dr && !ex_dg) m_waited = m_waited + 1;
        else m_waited = 0;
        ex_lk = m_locked;
        #1;
        ob_fv = f_rvalid_o; ob_fd = f_rdata_o; ob_fe = f_err_o;
        ob_dv = d_rvalid_o; ob_dd = d_rdata_o; ob_de = d_err_o; ob_lk = locked_o;
    endtask

    task automatic test_reset;
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++; if (f_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
            bad++; $display("FAIL reset_rvalid got f=%b d=%b exp 0", f_rvalid_o, d_rvalid_o); end
        total++; if (f_rdata_o !== 32'd0 || d_rdata_o !== 32'd0) begin
            bad++; $display("FAIL reset_rdata got f=%h d=%h exp 0", f_rdata_o, d_rdata_o); end
        total++; if (f_err_o !== 1'b0 || d_err_o !== 1'b0 || locked_o !== 1'b0) begin
            bad++; $display("FAIL reset_err_lock got fe=%b de=%b lk=%b exp 0", f_err_o, d_err_o, locked_o); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        m_locked = 1'b0; m_waited = 0;
    endtask

    task automatic test_single_fetch;
        preload(32'h10, 8'h13); preload(32'h11, 8'h05);
        preload(32'h12, 8'h50); preload(32'h13, 8'h00);
        cyc(1, 32'h10, 0, 0, 0, 0, 0);
        total++; if (ob_fg !== 1'b1 || ob_dg !== 1'b0) begin
            bad++; $display("FAIL single_gnt got f=%b d=%b exp f=1 d=0", ob_fg, ob_dg); end
        total++; if (ob_fv !== 1'b1 || ob_fd !== 32'h00500513 || ob_fe !== 1'b0) begin
            bad++; $display("FAIL single_resp got v=%b d=%h e=%b exp v=1 d=00500513 e=0", ob_fv, ob_fd, ob_fe); end
    endtask

    task automatic test_starvation;
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 32'h100 + 32'(4 * i), (i <= 4), 0, 0, 32'h20, 0);
            total++; if (ob_fg !== (i != 4) || ob_dg !== (i == 4)) begin
                bad++; $display("FAIL starve_cycle%0d got f=%b d=%b exp f=%b d=%b", i, ob_fg, ob_dg, i != 4, i == 4); end
        end
        total++; if (ob_dv !== 1'b0 || ob_fv !== 1'b1) begin
            bad++; $display("FAIL starve_resp got fv=%b dv=%b exp fv=1 dv=0", ob_fv, ob_dv); end
    endtask

    task automatic test_lock_load;
        cyc(0, 32'h40, 1, 1, 1, 32'h0, 32'hDEADBEEF);
        total++; if (ob_dg !== 1'b1 || ob_we !== 1'b1 || ob_addr !== 32'h0) begin
            bad++; $display("FAIL lock_write got g=%b we=%b a=%h exp g=1 we=1 a=0", ob_dg, ob_we, ob_addr); end
        total++; if (ob_lk !== 1'b1 || ob_dv !== 1'b1 || ob_dd !== 32'd0 || ob_de !== 1'b0) begin
            bad++; $display("FAIL lock_rise got lk=%b dv=%b dd=%h de=%b exp 1 1 0 0", ob_lk, ob_dv, ob_dd, ob_de); end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h44, 0, 0, 1, 0, 0);
            total++; if (ob_fg !== 1'b0 || ob_we !== 1'b0 || ob_lk !== 1'b1) begin
                bad++; $display("FAIL lock_hold%0d got fg=%b we=%b lk=%b exp 0 0 1", i, ob_fg, ob_we, ob_lk); end
        end
        cyc(1, 32'h44, 1, 0, 1, 32'h0, 0);
        total++; if (ob_fg !== 1'b0 || ob_dv !== 1'b1 || ob_dd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lock_read got fg=%b dv=%b dd=%h exp 0 1 deadbeef", ob_fg, ob_dv, ob_dd); end
        cyc(1, 32'h44, 1, 0, 0, 32'h10, 0);
        total++; if (ob_fg !== 1'b0 || ob_dg !== 1'b1 || ob_lk !== 1'b0) begin
            bad++; $display("FAIL unlock got fg=%b dg=%b lk=%b exp 0 1 0", ob_fg, ob_dg, ob_lk); end
        cyc(1, 32'h0, 0, 0, 0, 0, 0);
        total++; if (ob_fg !== 1'b1 || ob_fd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fetch_resume got fg=%b fd=%h exp 1 deadbeef", ob_fg, ob_fd); end
    endtask

    task automatic test_out_of_range;
        cyc(1, 32'h3FD, 0, 0, 0, 0, 0);
        total++; if (ob_fv !== 1'b1 || ob_fd !== 32'd0 || ob_fe !== 1'b1) begin
            bad++; $display("FAIL oor_3fd got v=%b d=%h e=%b exp 1 0 1", ob_fv, ob_fd, ob_fe); end
        cyc(1, 32'h3FC, 0, 0, 0, 0, 0);
        total++; if (ob_fv !== 1'b1 || ob_fe !== 1'b0 || ob_fd !== ex_fd) begin
            bad++; $display("FAIL oor_3fc got v=%b d=%h e=%b exp 1 %h 0", ob_fv, ob_fd, ob_fe, ex_fd); end
        cyc(0, 0, 1, 1, 0, 32'h400, 32'h12345678);
        total++; if (ob_dg !== 1'b1 || ob_we !== 1'b0 || ob_de !== 1'b1 || ob_dv !== 1'b1) begin
            bad++; $display("FAIL oor_write got g=%b we=%b e=%b v=%b exp 1 0 1 1", ob_dg, ob_we, ob_de, ob_dv); end
        cyc(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
        total++; if (ob_fe !== 1'b1 || ob_fd !== 32'd0) begin
            bad++; $display("FAIL oor_high got e=%b d=%h exp 1 0", ob_fe, ob_fd); end
    endtask

    task automatic test_reset_mid_lock;
        cyc(0, 0, 1, 1, 1, 32'h40, 32'h11223344);
        total++; if (ob_lk !== 1'b1) begin
            bad++; $display("FAIL rml_locked got %b exp 1", ob_lk); end
        @(negedge clk_i);
        f_req_i = 1'b1; f_addr_i = 32'h50;
        d_req_i = 1'b1; d_we_i = 1'b1; d_lock_i = 1'b1; d_addr_i = 32'h40; d_wdata_i = 32'h55667788;
        #1;
        total++; if (d_gnt_o !== 1'b1 || mem_we_o !== 1'b1) begin
            bad++; $display("FAIL rml_pending got dg=%b we=%b exp 1 1", d_gnt_o, mem_we_o); end
        rstn_i = 1'b0;
        #1;
        total++; if (f_gnt_o !== 1'b0 || d_gnt_o !== 1'b0 || mem_we_o !== 1'b0 || locked_o !== 1'b0) begin
            bad++; $display("FAIL rml_async got fg=%b dg=%b we=%b lk=%b exp 0", f_gnt_o, d_gnt_o, mem_we_o, locked_o); end
        @(posedge clk_i); #1;
        total++; if (f_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
            bad++; $display("FAIL rml_rvalid got f=%b d=%b exp 0", f_rvalid_o, d_rvalid_o); end
        @(negedge clk_i);
        rstn_i = 1'b1; d_req_i = 1'b0;
        m_locked = 1'b0; m_waited = 0;
        #1;
        total++; if (f_gnt_o !== 1'b1) begin
            bad++; $display("FAIL rml_release got fg=%b exp 1", f_gnt_o); end
        f_req_i = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h40, 0, 0, 0, 0, 0);
        total++; if (ob_fd !== 32'h11223344) begin
            bad++; $display("FAIL rml_mem got %h exp 11223344", ob_fd); end
    endtask

    task automatic test_random;
        bit          fp = 0, dp = 0, dwe = 0, dl = 0;
        logic [31:0] fa = 0, da = 0, dw = 0;
        for (int n = 0; n < 600; n++) begin
            if (!fp && $urandom_range(0, 3) != 0) begin
                fp = 1;
                fa = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1;
                dwe = $urandom_range(0, 1) != 0;
                da = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
                dw = $urandom;
                dl = m_locked ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 7) == 0);
            end
            cyc(fp, fa, dp, dwe, dl, da, dw);
            total++; if (ob_fg !== ex_fg || ob_dg !== ex_dg || ob_we !== ex_we) begin
                bad++; $display("FAIL rnd_gnt n=%0d got fg=%b dg=%b we=%b exp %b %b %b", n, ob_fg, ob_dg, ob_we, ex_fg, ex_dg, ex_we); end
            total++; if (ob_addr !== ex_addr || ob_lk !== ex_lk) begin
                bad++; $display("FAIL rnd_addr n=%0d got a=%h lk=%b exp a=%h lk=%b", n, ob_addr, ob_lk, ex_addr, ex_lk); end
            total++; if (ob_fv !== ex_fv || ob_dv !== ex_dv) begin
                bad++; $display("FAIL rnd_valid n=%0d got fv=%b dv=%b exp %b %b", n, ob_fv, ob_dv, ex_fv, ex_dv); end
            if (ex_fv) begin
                total++; if (ob_fd !== ex_fd || ob_fe !== ex_fe) begin
                    bad++; $display("FAIL rnd_fresp n=%0d got d=%h e=%b exp %h %b", n, ob_fd, ob_fe, ex_fd, ex_fe); end
            end
            if (ex_dv) begin
                total++; if (ob_dd !== ex_dd || ob_de !== ex_de) begin
                    bad++; $display("FAIL rnd_dresp n=%0d got d=%h e=%b exp %h %b", n, ob_dd, ob_de, ex_dd, ex_de); end
            end
            if (ex_fg) fp = 0;
            if (ex_dg) dp = 0;
        end
        // Release any lock left by the random run
        cyc(0, 0, 1, 0, 0, 32'h0, 0);
        total++; if (ob_lk !== 1'b0) begin
            bad++; $display("FAIL rnd_unlock got %b exp 0", ob_lk); end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]   = 8'($urandom);
            m_mem[i] = mem[i];
        end
        test_reset;
        test_single_fetch;
        test_starvation;
        test_lock_load;
        test_out_of_range;
        test_reset_mid_lock;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single byte-addressed instruction-memory port between the core's fetch stage and the debug/program-load port. Grants one transaction per cycle and registers the read data with one cycle of latency. Bounds debug starvation with a wait counter and lets the debug port lock the memory, which holds the core off while a program is loaded. It sits between the fetch unit, the debug/loader and the instruction memory.

## Interface
- `MEM_BYTES`, 1024: memory size in bytes; a word access is legal when addr <= MEM_BYTES-4.
- `MAX_WAIT`, 4: cycles a pending debug request waits before it overrides fetch (1..15).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `f_req_i`  in  1  fetch request; held until granted.
- `f_addr_i`  in  32  fetch byte address.
- `f_gnt_o`  out  1  fetch granted this cycle (combinational).
- `f_rvalid_o`  out  1  fetch response valid (one-cycle pulse).
- `f_rdata_o`  out  32  fetch read data.
- `f_err_o`  out  1  fetch response was out of range; qualified by `f_rvalid_o`.
- `d_req_i`  in  1  debug request; held until granted.
- `d_we_i`  in  1  debug write (1) / read (0).
- `d_lock_i`  in  1  request or keep exclusive ownership.
- `d_addr_i`  in  32  debug byte address.
- `d_wdata_i`  in  32  debug write data, little-endian.
- `d_gnt_o`  out  1  debug granted this cycle (combinational).
- `d_rvalid_o`  out  1  debug response valid; pulses for reads and for writes.
- `d_rdata_o`  out  32  debug read data; 0 for writes.
- `d_err_o`  out  1  debug response was out of range.
- `locked_o`  out  1  arbiter is in the LOCKED state; the core stalls on this.
- `mem_addr_o`  out  32  memory byte address.
- `mem_we_o`  out  1  memory write strobe, for one cycle.
- `mem_wdata_o`  out  32  memory write data.
- `mem_rdata_i`  in  32  combinational read data from memory: {b[a+3],b[a+2],b[a+1],b[a]}.

## Operation
- **States:**
  - SHARED: the reset state.
  - LOCKED.
- **Arbitration, evaluated combinationally each cycle:**
  - In LOCKED, only debug can be granted. `f_gnt_o` = 0.
  - In SHARED, debug wins when d_req_i && (!f_req_i || wait_cnt == MAX_WAIT). Otherwise fetch wins if f_req_i.
  - At most one grant per cycle; the grants are never both high.
- **wait_cnt (4 bit):**
  - Increments when d_req_i && !d_gnt_o, saturating at MAX_WAIT.
  - Clears to 0 on a debug grant or when d_req_i = 0.
- **Transitions:**
  - SHARED→LOCKED on a debug grant with d_lock_i = 1.
  - LOCKED→SHARED on a debug grant with d_lock_i = 0.
  - No other transitions.
- **Memory drive:**
  - `mem_addr_o` = the winner's address. When idle it is f_addr_i.
  - `mem_we_o` = d_gnt_o && d_we_i && in_range.
  - `mem_wdata_o` = d_wdata_i.
- **Range:**
  - in_range = (addr <= MEM_BYTES-4).
  - An out-of-range write is suppressed and responds with err = 1.
  - An out-of-range read responds with rdata = 0 and err = 1.
  - Unaligned in-range reads are legal and return bytes addr..addr+3.
- **Width:** compare addresses as unsigned 32-bit. MEM_BYTES-4 is computed in 32 bits.

## Timing
- A grant is in the same cycle as the request.
- The response (`*_rvalid_o`, `*_rdata_o`, `*_err_o`) is registered and appears exactly one cycle after the grant, for exactly one cycle.
- `mem_rdata_i` is sampled on the granting edge.
- Back-to-back grants to the same requester give back-to-back responses. Throughput is 1 transaction per cycle.
- A requester may drop its request only after its grant. Dropping earlier is legal but aborts the request without a response.
- **Reset values:**
  - Outputs: rvalid = 0, rdata = 0, err = 0, `locked_o` = 0.
  - Internal state: state = SHARED, wait_cnt = 0.
- Asserting `rstn_i` mid-transaction:
  - Drops any pending response.
  - Exits LOCKED immediately.
  - `mem_we_o` goes to 0 asynchronously, because it is gated by the grants.
- Simultaneous f_req_i and d_req_i with wait_cnt < MAX_WAIT: fetch wins.
- `locked_o` is registered. It rises the cycle after the locking grant and falls the cycle after the unlocking grant.

## Test plan
- **Single fetch:** f_req_i = 1, f_addr_i = 0x10, memory bytes 0x10..0x13 = 0x13,0x05,0x50,0x00. Require `f_gnt_o` high that cycle, then `f_rvalid_o` = 1 and `f_rdata_o` = 0x00500513 one cycle later, with `f_err_o` = 0.
- **Starvation:** f_req_i held high and d_req_i raised at cycle 0 with MAX_WAIT = 4. Require fetch grants in cycles 0-3, `d_gnt_o` in cycle 4, and fetch granted again in cycle 5.
- **Lock/load:** debug writes 0xDEADBEEF to 0x0 with d_lock_i = 1.
  - Require `mem_we_o` for 1 cycle, `locked_o` = 1 from the next cycle, and `f_gnt_o` = 0 for the whole lock.
  - A debug read of 0x0 returns 0xDEADBEEF.
  - A final grant with d_lock_i = 0 clears `locked_o` and fetch resumes.
- **Out of range:**
  - A fetch at 0x3FD returns rdata = 0 with err = 1.
  - A fetch at 0x3FC returns err = 0.
  - A debug write at 0x400 leaves `mem_we_o` = 0 and `d_err_o` = 1.
- **Reset mid-lock:** pull `rstn_i` low while LOCKED with a response pending. Require `locked_o`, the rvalid outputs and the grants at 0 immediately, and fetch granted on the first cycle after release.
